// File: rtl/imuldiv_int_mul_iterative_param.sv
// Iterative shift-add integer multiplier that retires STEP bits of B per cycle.
// Signed requests multiply magnitudes and negate the 2*W-bit product in DONE.
module imuldiv_int_mul_iterative_param #(
  parameter int unsigned W    = 32,
  parameter int unsigned STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     mulreq_msg_a,
  input  logic [W-1:0]     mulreq_msg_b,
  input  logic             mulreq_msg_signed,
  input  logic             mulreq_val,
  output logic             mulreq_rdy,
  output logic [2*W-1:0]   mulresp_msg_result,
  output logic             mulresp_val,
  input  logic             mulresp_rdy
);

  localparam int unsigned N  = W / STEP;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_next;
  logic [2*W-1:0]   r_a, r_acc, w_pp;
  logic [W-1:0]     r_b, w_a_mag, w_b_mag;
  logic             r_neg, w_last;
  logic [CW-1:0]    r_cnt;

  assign w_a_mag = (mulreq_msg_signed && mulreq_msg_a[W-1]) ? -mulreq_msg_a : mulreq_msg_a;
  assign w_b_mag = (mulreq_msg_signed && mulreq_msg_b[W-1]) ? -mulreq_msg_b : mulreq_msg_b;
  assign w_last  = (r_cnt == CW'(N - 1));

  always_comb begin
    w_pp = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (r_b[i]) w_pp = w_pp + (r_a << i);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (mulreq_val)  w_next = CALC;
      CALC:    if (w_last)      w_next = DONE;
      DONE:    if (mulresp_rdy) w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  assign mulreq_rdy         = (r_state == IDLE);
  assign mulresp_val        = (r_state == DONE);
  assign mulresp_msg_result = (r_state == DONE) ? (r_neg ? -r_acc : r_acc) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (mulreq_val) begin
          r_a   <= {{W{1'b0}}, w_a_mag};
          r_b   <= w_b_mag;
          r_neg <= mulreq_msg_signed & (mulreq_msg_a[W-1] ^ mulreq_msg_b[W-1]);
          r_acc <= '0;
          r_cnt <= '0;
        end
        CALC: begin
          r_acc <= r_acc + w_pp;
          r_a   <= r_a << STEP;
          r_b   <= r_b >> STEP;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_int_mul_iterative_param.sv
// Scoreboard bench for the iterative multiplier at W=32/STEP=1 and W=16/STEP=4.
module tb_imuldiv_int_mul_iterative_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] a32, b32;
  logic        s32, v32, rq32, rv32, rr32;
  logic [63:0] res32;
  logic [15:0] a16, b16;
  logic        s16, v16, rq16, rv16, rr16;
  logic [31:0] res16;

  int checks = 0;
  int errors = 0;
  logic [63:0] q32[$];
  logic [31:0] q16[$];
  time t_acc32;

  imuldiv_int_mul_iterative_param #(.W(32), .STEP(1)) dut32 (
    .clk(clk), .reset(reset),
    .mulreq_msg_a(a32), .mulreq_msg_b(b32), .mulreq_msg_signed(s32),
    .mulreq_val(v32), .mulreq_rdy(rq32),
    .mulresp_msg_result(res32), .mulresp_val(rv32), .mulresp_rdy(rr32)
  );

  imuldiv_int_mul_iterative_param #(.W(16), .STEP(4)) dut16 (
    .clk(clk), .reset(reset),
    .mulreq_msg_a(a16), .mulreq_msg_b(b16), .mulreq_msg_signed(s16),
    .mulreq_val(v16), .mulreq_rdy(rq16),
    .mulresp_msg_result(res16), .mulresp_val(rv16), .mulresp_rdy(rr16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop expectation on every response handshake.
  always @(negedge clk) begin
    if (!reset && rv32 && rr32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp32_unexpected actual=0x%0h required=none", res32);
      end else chk("resp32", res32, q32.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!reset && rv16 && rr16) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp16_unexpected actual=0x%0h required=none", res16);
      end else chk("resp16", {32'b0, res16}, {32'b0, q16.pop_front()});
    end
  end

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input logic push);
    int n = 0;
    @(negedge clk);
    while (!rq32 && n < 200) begin @(negedge clk); n++; end
    if (!rq32) chk("req32_rdy_timeout", {63'b0, rq32}, 64'd1);
    a32 = a; b32 = b; s32 = s; v32 = 1'b1;
    if (push) q32.push_back(exp);
    @(posedge clk);
    t_acc32 = $time;
    #1 v32 = 1'b0;
  endtask

  task automatic wait_resp32(output int lat);
    lat = 0;
    while (!rv32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    while (!rq16 && n < 200) begin @(negedge clk); n++; end
    if (!rq16) chk("req16_rdy_timeout", {63'b0, rq16}, 64'd1);
    a16 = a; b16 = b; s16 = s; v16 = 1'b1;
    q16.push_back(exp);
    @(posedge clk);
    #1 v16 = 1'b0;
  endtask

  initial begin
    int lat;
    time t_prev, t_hs;
    logic [63:0] vec_a[5], vec_b[5], vec_e[5];
    logic        vec_s[5];
    logic [15:0] ra, rb;
    logic        rs;
    int          sa, sb, sp;
    logic [31:0] ue;
    logic        seen;

    reset = 1'b1;
    a32 = '0; b32 = '0; s32 = 1'b0; v32 = 1'b0; rr32 = 1'b1;
    a16 = '0; b16 = '0; s16 = 1'b0; v16 = 1'b0; rr16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_rdy", {63'b0, rq32}, 64'd1);
    chk("reset_resp_val", {63'b0, rv32}, 64'd0);
    chk("reset_result", res32, 64'd0);
    @(negedge clk) reset = 1'b0;

    // Unsigned 3 x 4, latency and ready return after handshake
    issue32(32'd3, 32'd4, 1'b0, 64'h0000_0000_0000_000C, 1'b1);
    wait_resp32(lat);
    chk("lat_3x4", 64'(lat), 64'd32);
    @(posedge clk); #1;
    chk("rdy_after_hs", {63'b0, rq32}, 64'd1);
    chk("val_after_hs", {63'b0, rv32}, 64'd0);

    vec_a = '{64'hFFFFFFFF, 64'h80000000, 64'h80000000, 64'hFFFFFFFF, 64'h00001234};
    vec_b = '{64'hFFFFFFFF, 64'h80000000, 64'h00000001, 64'hFFFFFFFF, 64'hFFFFFFFE};
    vec_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vec_e = '{64'h0000000000000001, 64'h4000000000000000, 64'hFFFFFFFF80000000,
              64'hFFFFFFFE00000001, 64'hFFFFFFFFFFFFDB98};
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      issue32(vec_a[i][31:0], vec_b[i][31:0], vec_s[i], vec_e[i], 1'b1);
      if (i > 0) chk("throughput", 64'(t_acc32 - t_prev), 64'd340);
      t_prev = t_acc32;
      wait_resp32(lat);
      chk("lat_vec", 64'(lat), 64'd32);
    end

    // Backpressure in DONE
    @(negedge clk);
    while (!rq32) @(negedge clk);
    rr32 = 1'b0;
    issue32(32'h0001_0000, 32'h0003_0000, 1'b0, 64'h0000_0003_0000_0000, 1'b1);
    wait_resp32(lat);
    chk("lat_bp", 64'(lat), 64'd32);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v32 = i[0]; a32 = 32'd5; b32 = 32'd5; s32 = 1'b0;
      @(posedge clk); #1;
      chk("bp_val", {63'b0, rv32}, 64'd1);
      chk("bp_result", res32, 64'h0000_0003_0000_0000);
      chk("bp_req_rdy", {63'b0, rq32}, 64'd0);
    end
    @(negedge clk);
    v32 = 1'b0; rr32 = 1'b1;
    @(posedge clk);
    t_hs = $time;
    #1 chk("rdy_after_bp", {63'b0, rq32}, 64'd1);
    issue32(32'd7, 32'd9, 1'b0, 64'd63, 1'b1);
    chk("accept_after_bp", 64'(t_acc32 - t_hs), 64'd10);
    wait_resp32(lat);
    chk("lat_7x9", 64'(lat), 64'd32);

    // Reset in the middle of CALC drops the operation
    issue32(32'd1234, 32'd5678, 1'b0, 64'd0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_rdy", {63'b0, rq32}, 64'd1);
    chk("abort_resp_val", {63'b0, rv32}, 64'd0);
    chk("abort_result", res32, 64'd0);
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rv32) seen = 1'b1;
    end
    chk("abort_no_resp", {63'b0, seen}, 64'd0);
    issue32(32'd7, 32'd6, 1'b0, 64'd42, 1'b1);
    wait_resp32(lat);
    chk("lat_7x6", 64'(lat), 64'd32);

    // W=16, STEP=4
    issue16(16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
    lat = 0;
    while (!rv16 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("lat16", 64'(lat), 64'd4);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 50 == 0) ra = 16'h8000;
      if (i % 70 == 0) rb = 16'hFFFF;
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        sa = $signed(ra);
        sb = $signed(rb);
        sp = sa * sb;
        ue = sp;
      end else begin
        ue = {16'b0, ra} * {16'b0, rb};
      end
      issue16(ra, rb, rs, ue);
    end

    for (int i = 0; i < 200 && (q32.size() != 0 || q16.size() != 0); i++) @(posedge clk);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain16", 64'(q16.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
